// File: rtl/tt_sweep_ctrl_if.sv
// Bus between the sweep controller and its requester / gate-under-test.
// The master side issues sweep requests and closes the loop through the gate.
interface tt_sweep_ctrl_if;
  logic       start;
  logic [3:0] expect_tt;
  logic       dut_s;
  logic       dut_a;
  logic       dut_b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] captured_tt;
  logic [3:0] fail_mask;

  modport master (
    output start, expect_tt, dut_s,
    input  dut_a, dut_b, busy, done, pass, captured_tt, fail_mask
  );

  modport slave (
    input  start, expect_tt, dut_s,
    output dut_a, dut_b, busy, done, pass, captured_tt, fail_mask
  );
endinterface

// File: rtl/tt_sweep_ctrl.sv
// Clocked truth-table sweep of a 2-input gate: drives minterms 0..3, waits SETTLE
// cycles each, samples the gate output and compares it against a latched expectation.
module tt_sweep_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic            clk,
  input  logic            clear,
  tt_sweep_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic [1:0] m, m_nx;
  logic [3:0] exp_q, exp_nx;
  logic [3:0] cap, cap_nx;
  logic [3:0] fm, fm_nx;
  logic       busy_q, busy_nx;
  logic       done_q, done_nx;
  logic       pass_q, pass_nx;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state  <= IDLE;
      cnt    <= '0;
      m      <= '0;
      exp_q  <= '0;
      cap    <= '0;
      fm     <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      m      <= m_nx;
      exp_q  <= exp_nx;
      cap    <= cap_nx;
      fm     <= fm_nx;
      busy_q <= busy_nx;
      done_q <= done_nx;
      pass_q <= pass_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    m_nx     = m;
    exp_nx   = exp_q;
    cap_nx   = cap;
    fm_nx    = fm;
    busy_nx  = busy_q;
    done_nx  = done_q;
    pass_nx  = pass_q;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          exp_nx   = bus.expect_tt;
          m_nx     = 2'd0;
          cap_nx   = 4'd0;
          fm_nx    = 4'd0;
          busy_nx  = 1'b1;
          done_nx  = 1'b0;
          pass_nx  = 1'b0;
          cnt_nx   = SETTLE_LD;
          state_nx = APPLY;
        end
      end
      APPLY: begin
        cnt_nx = cnt - 4'd1;
        if (cnt == 4'd1) state_nx = SAMPLE;
      end
      SAMPLE: begin
        cap_nx[m] = bus.dut_s;
        fm_nx[m]  = bus.dut_s ^ exp_q[m];
        // the last minterm exits to DONE, so m never wraps
        if (m == 2'd3) begin
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
          pass_nx  = (fm_nx == 4'd0);
          state_nx = DONE;
        end else begin
          m_nx     = m + 2'd1;
          cnt_nx   = SETTLE_LD;
          state_nx = APPLY;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // the minterm register doubles as the registered gate drive
  assign bus.dut_a       = m[1];
  assign bus.dut_b       = m[0];
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.pass        = pass_q;
  assign bus.captured_tt = cap;
  assign bus.fail_mask   = fm;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Bench for tt_sweep_ctrl: two instances (SETTLE=1 and 3) sweeping modelled gates,
// checked cycle by cycle against a timing/truth-table model.
module tb_tt_sweep_ctrl;

  localparam int S_A = 1;
  localparam int S_B = 3;
  localparam int G_NAND = 0, G_AND = 1, G_OR = 2, G_NOR = 3, G_XOR = 4, G_XNOR = 5;

  if (S_A < 1 || S_A > 15 || S_B < 1 || S_B > 15) begin : g_bad_settle
    initial $fatal(1, "FAIL settle_range SETTLE outside 1..15");
  end

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic       sel = 1'b0;
  logic       start = 1'b0;
  logic       glitch = 1'b0;
  logic [3:0] expect_tt = 4'd0;
  int         gate = G_NAND;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  function automatic logic gate_out(input int g, input logic a, input logic b);
    case (g)
      G_NAND:  return ~(a & b);
      G_AND:   return a & b;
      G_OR:    return a | b;
      G_NOR:   return ~(a | b);
      G_XOR:   return a ^ b;
      default: return ~(a ^ b);
    endcase
  endfunction

  // expected truth table: evaluate the gate at every minterm {a,b}
  function automatic logic [3:0] model_tt(input int g);
    logic [3:0] t;
    logic [1:0] mm;
    t = 4'd0;
    for (int i = 0; i < 4; i++) begin
      mm   = 2'(i);
      t[i] = gate_out(g, mm[1], mm[0]);
    end
    return t;
  endfunction

  tt_sweep_ctrl_if bus_a ();
  tt_sweep_ctrl_if bus_b ();

  assign bus_a.start     = start & ~sel;
  assign bus_b.start     = start & sel;
  assign bus_a.expect_tt = expect_tt;
  assign bus_b.expect_tt = expect_tt;
  assign bus_a.dut_s     = gate_out(gate, bus_a.dut_a, bus_a.dut_b) ^ (glitch & ~sel);
  assign bus_b.dut_s     = gate_out(gate, bus_b.dut_a, bus_b.dut_b) ^ (glitch & sel);

  tt_sweep_ctrl #(.SETTLE(S_A)) u_s1 (.clk(clk), .clear(clear), .bus(bus_a));
  tt_sweep_ctrl #(.SETTLE(S_B)) u_s3 (.clk(clk), .clear(clear), .bus(bus_b));

  logic       o_a, o_b, o_busy, o_done, o_pass;
  logic [3:0] o_cap, o_fm;

  always_comb begin
    o_a    = sel ? bus_b.dut_a       : bus_a.dut_a;
    o_b    = sel ? bus_b.dut_b       : bus_a.dut_b;
    o_busy = sel ? bus_b.busy        : bus_a.busy;
    o_done = sel ? bus_b.done        : bus_a.done;
    o_pass = sel ? bus_b.pass        : bus_a.pass;
    o_cap  = sel ? bus_b.captured_tt : bus_a.captured_tt;
    o_fm   = sel ? bus_b.fail_mask   : bus_a.fail_mask;
  end

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b (sel=%0b t=%0t)", tag, obs, expv, sel, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ab"},   {2'b00, o_a, o_b}, 4'd0);
    chk({tag, "_flags"}, {1'b0, o_busy, o_done, o_pass}, 4'd0);
    chk({tag, "_cap"},  o_cap, 4'd0);
    chk({tag, "_fm"},   o_fm, 4'd0);
  endtask

  // One sweep; called #1 after a rising edge. pulses[k] drives start into edge k,
  // abort_at>0 pulls clear low asynchronously after that edge.
  task automatic run_sweep(input logic s, input int g, input logic [3:0] ex,
                           input logic [31:0] pulses, input logic glitchy,
                           input logic hold, input int abort_at);
    int         st;
    int         total;
    int         ab;
    logic [3:0] ett;
    logic [3:0] efm;
    st    = s ? S_B : S_A;
    total = 4 * (st + 1);
    ett   = model_tt(g);
    efm   = ett ^ ex;
    sel = s; gate = g; expect_tt = ex; start = 1'b1; glitch = 1'b0;
    @(posedge clk); #1;
    expect_tt = 4'($urandom);
    chk("accept_ab", {2'b00, o_a, o_b}, 4'd0);
    chk("accept_flags", {1'b0, o_busy, o_done, o_pass}, 4'b0100);
    chk("accept_cap", o_cap, 4'd0);
    chk("accept_fm", o_fm, 4'd0);
    for (int k = 1; k <= total; k++) begin
      start  = pulses[k];
      glitch = (glitchy && (k % (st + 1) != 0)) ? 1'($urandom) : 1'b0;
      @(posedge clk); #1;
      if (abort_at == k) begin
        #1 clear = 1'b0;
        #1 chk_all_zero("abort");
        start = 1'b0; glitch = 1'b0;
        #1 clear = 1'b1;
        return;
      end
      ab = k / (st + 1);
      if (ab > 3) ab = 3;
      chk("ab_seq", {2'b00, o_a, o_b}, 4'(ab));
      chk("busy", {3'b000, o_busy}, {3'b000, (k < total)});
      chk("done", {3'b000, o_done}, {3'b000, (k >= total)});
    end
    glitch = 1'b0;
    start  = hold;
    chk("captured_tt", o_cap, ett);
    chk("fail_mask", o_fm, efm);
    chk("pass", {3'b000, o_pass}, {3'b000, (efm == 4'd0)});
  endtask

  initial begin
    int         rs;
    int         rg;
    int         tot;
    int         ab_at;
    logic       rh;
    #2;
    sel = 1'b0; #1 chk_all_zero("reset_s1");
    sel = 1'b1; #1 chk_all_zero("reset_s3");
    @(posedge clk); #1 chk_all_zero("reset_held_s3");
    sel = 1'b0;
    @(negedge clk); clear = 1'b1;
    @(posedge clk); #1;

    run_sweep(1'b0, G_NAND, 4'b0111, 32'd0, 1'b0, 1'b0, 0);
    run_sweep(1'b0, G_AND,  4'b0111, 32'd0, 1'b0, 1'b0, 0);
    run_sweep(1'b0, G_NAND, 4'b0110, 32'd0, 1'b0, 1'b0, 0);
    run_sweep(1'b0, G_NAND, 4'b0111, (32'd1 << 3) | (32'd1 << 5), 1'b0, 1'b0, 0);
    run_sweep(1'b0, G_NAND, 4'b0111, 32'd0, 1'b0, 1'b0, 5);
    run_sweep(1'b0, G_NAND, 4'b0111, 32'd0, 1'b0, 1'b0, 0);
    run_sweep(1'b1, G_NAND, 4'b0111, 32'd0, 1'b0, 1'b1, 0);
    run_sweep(1'b1, G_NAND, 4'b0111, 32'd0, 1'b0, 1'b0, 0);
    run_sweep(1'b1, G_OR,   4'b1110, 32'd0, 1'b0, 1'b0, 0);

    for (int it = 0; it < 30; it++) begin
      rs    = int'($urandom_range(0, 1));
      rg    = int'($urandom_range(0, 5));
      rh    = 1'($urandom);
      tot   = 4 * ((rs != 0 ? S_B : S_A) + 1);
      ab_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, tot)) : 0;
      run_sweep(rs[0], rg, 4'($urandom), $urandom, 1'b1, rh, ab_at);
      if (!start) repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    start = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tt_sweep_ctrl.md
Name: tt_sweep_ctrl

Overview:
- Sequencer that sweeps a 2-input combinational gate-under-test (NAND, AND, OR, or any other 2-input gate module in the guide library) through all four minterms.
- Drives a/b, waits a settle interval, samples s, and compares each result against an expected truth-table code.
- Reports the captured truth table, a per-minterm mismatch mask and a pass flag.
- Sits between a bench or top-level controller and the gate instance; replaces hand-written #1 stimulus sequences with a clocked, self-checking sweep.

Parameters:
- SETTLE, 1, cycles a/b are held before s is sampled; legal range 1..15.

Ports:
- clk  input  1  system clock, rising-edge active
- clear  input  1  asynchronous reset, active-low
- start  input  1  sweep request, sampled on clk rising edge
- expect_tt  input  4  expected s per minterm; bit m = s for {a,b}=m; latched at accepted start
- dut_s  input  1  output of gate-under-test
- dut_a  output  1  gate input a (MSB of minterm), registered
- dut_b  output  1  gate input b (LSB of minterm), registered
- busy  output  1  sweep in progress
- done  output  1  sweep complete; results valid; level, held until next accepted start or clear
- pass  output  1  1 when fail_mask==0; meaningful only while done=1
- captured_tt  output  4  sampled s per minterm, bit m
- fail_mask  output  4  bit m = captured_tt[m] XOR expected[m]

Behaviour:
- Reset, clear=0, asynchronous and immediate:
  - state=IDLE, minterm counter m=0, settle counter=0
  - dut_a=0, dut_b=0, busy=0, done=0, pass=0, captured_tt=0000, fail_mask=0000, expect latch=0000
- Reset mid-sweep aborts the sweep. No partial results are retained. Operation resumes on the first edge after clear returns to 1.
- States: IDLE, APPLY, SAMPLE, DONE.
- IDLE or DONE, start=1 at an edge (accept):
  - latch expect_tt
  - m=0, dut_a=0, dut_b=0
  - clear captured_tt and fail_mask
  - done=0, pass=0, busy=1
  - load settle counter with SETTLE; go to APPLY
- APPLY:
  - settle counter decrements each edge
  - when the counter is 1 at an edge, go to SAMPLE
  - dut_a/dut_b are held stable throughout
- SAMPLE, single cycle:
  - at the edge, captured_tt[m] <= dut_s and fail_mask[m] <= dut_s XOR expect[m]
  - m<3: m <= m+1; {dut_a,dut_b} <= m+1; reload settle counter; go to APPLY
  - m==3: go to DONE; busy=0; done=1; pass = (final fail_mask==0000), including the bit written on this edge
  - {dut_a,dut_b} stays 11 in DONE
- Timing:
  - each minterm costs SETTLE+1 cycles
  - done rises 4*(SETTLE+1) edges after the accepting edge (8 edges for SETTLE=1)
  - busy is high for exactly that many cycles
- start while busy=1 is ignored: no restart, expect latch unchanged.
- start held high continuously in DONE re-accepts on the next edge. done is high for one cycle per sweep in that case.
- expect_tt changes after accept have no effect on the current sweep.
- m is a 2-bit counter. No wrap past 3 occurs; the SAMPLE-at-3 transition always exits to DONE.
- dut_s is sampled only in SAMPLE. Glitches on dut_s during APPLY are don't-care.
- SETTLE outside 1..15 is illegal; the bench flags it with an elaboration check.

Test Plan:
- Real NAND as DUT, expect_tt=4'b0111, SETTLE=1, 1-cycle start pulse:
  - dut_a/dut_b sequence 00,01,10,11, each held 2 cycles
  - done=1 at edge 8 after accept, busy low at the same edge
  - captured_tt=0111, fail_mask=0000, pass=1
- AND as DUT, expect_tt=4'b0111:
  - captured_tt=1000, fail_mask=1111, pass=0, done=1
- NAND DUT, expect_tt=4'b0110 (wrong expectation at m=0):
  - fail_mask=0001, pass=0
- start pulsed again at edges 3 and 5 of a running NAND sweep:
  - ignored; done still at edge 8; results identical to the first scenario
- clear=0 asserted asynchronously at edge 5, mid-sweep:
  - all outputs 0 immediately, with no wait for a clock edge
  - after release, a fresh start completes a normal 8-cycle sweep with pass=1
- SETTLE=3, NAND DUT, expect_tt=4'b0111:
  - each minterm held 4 cycles
  - done at edge 16, pass=1
  - a second start from DONE clears done/pass/captured_tt on the accepting edge and repeats with identical results
